// File: rtl/ex_weight_row_loader.sv
// ex_weight_row_loader
// Write-side sequencer for the expansion-weight row memory. Packs narrow
// valid/ready beats into one full memory row, then issues a single-cycle
// row write at base_index + row, repeating for num_rows rows.
module ex_weight_row_loader #(
  parameter int Data_Width  = 14,
  parameter int Lanes       = 256,
  parameter int Beat_Lanes  = 16,
  parameter int Height      = 938,
  parameter int Index_Width = 10
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [Index_Width-1:0]           base_index,
  input  logic [Index_Width-1:0]           num_rows,
  input  logic                             s_valid,
  input  logic [Beat_Lanes*Data_Width-1:0] s_data,
  output logic                             s_ready,
  output logic [Lanes*Data_Width-1:0]      mem_data,
  output logic [Index_Width-1:0]           mem_index,
  output logic                             mem_en,
  output logic                             mem_wr,
  output logic                             mem_rd,
  output logic                             busy,
  output logic                             done,
  output logic                             err
);

  localparam int BPR     = Lanes / Beat_Lanes;
  localparam int BEAT_W  = (BPR > 1) ? $clog2(BPR) : 1;
  localparam int SLICE_W = Beat_Lanes * Data_Width;

  localparam logic [Index_Width:0]   LP_HEIGHT = (Index_Width+1)'(Height);
  localparam logic [Index_Width-1:0] LP_ONE    = Index_Width'(1);
  localparam logic [BEAT_W-1:0]      LP_LAST   = BEAT_W'(BPR - 1);
  localparam logic [BEAT_W-1:0]      LP_BONE   = BEAT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                        r_state;
  logic [BPR-1:0][SLICE_W-1:0]   r_buf;
  logic [Index_Width-1:0]        r_base;
  logic [Index_Width-1:0]        r_num;
  logic [Index_Width-1:0]        r_row;
  logic [BEAT_W-1:0]             r_beat;
  logic [Index_Width-1:0]        r_mem_index;
  logic                          r_s_ready;
  logic                          r_mem_en;
  logic                          r_mem_wr;
  logic                          r_busy;
  logic                          r_done;
  logic                          r_err;

  logic [Index_Width:0]          w_end;
  logic                          w_bad_req;
  logic                          w_beat_hs;
  logic                          w_last_beat;
  logic                          w_last_row;

  // The end-row sum is one bit wider so base+num cannot wrap past Height.
  assign w_end       = {1'b0, base_index} + {1'b0, num_rows};
  assign w_bad_req   = (num_rows == '0) || (w_end > LP_HEIGHT);
  assign w_beat_hs   = s_valid && r_s_ready;
  assign w_last_beat = (r_beat == LP_LAST);
  assign w_last_row  = ((r_row + LP_ONE) == r_num);

  assign s_ready   = r_s_ready;
  assign mem_data  = r_buf;
  assign mem_index = r_mem_index;
  assign mem_en    = r_mem_en;
  assign mem_wr    = r_mem_wr;
  assign mem_rd    = 1'b0;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

  // Sequencer: all state, counters, row buffer and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_buf       <= '0;
      r_base      <= '0;
      r_num       <= '0;
      r_row       <= '0;
      r_beat      <= '0;
      r_mem_index <= '0;
      r_s_ready   <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (w_bad_req) begin
              r_err <= 1'b1;
            end else begin
              r_err     <= 1'b0;
              r_base    <= base_index;
              r_num     <= num_rows;
              r_row     <= '0;
              r_beat    <= '0;
              r_state   <= ST_FILL;
              r_s_ready <= 1'b1;
              r_busy    <= 1'b1;
            end
          end
        end

        ST_FILL: begin
          if (w_beat_hs) begin
            // Old lanes persist until overwritten; every row is fully
            // rewritten before its write, so no clearing is needed.
            r_buf[r_beat] <= s_data;
            if (w_last_beat) begin
              r_beat      <= '0;
              r_state     <= ST_WRITE;
              r_s_ready   <= 1'b0;
              r_mem_en    <= 1'b1;
              r_mem_wr    <= 1'b1;
              r_mem_index <= r_base + r_row;
            end else begin
              r_beat <= r_beat + LP_BONE;
            end
          end
        end

        ST_WRITE: begin
          r_mem_en <= 1'b0;
          r_mem_wr <= 1'b0;
          r_row    <= r_row + LP_ONE;
          if (w_last_row) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state   <= ST_FILL;
            r_s_ready <= 1'b1;
          end
        end

        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_state   <= ST_IDLE;
          r_s_ready <= 1'b0;
          r_mem_en  <= 1'b0;
          r_mem_wr  <= 1'b0;
          r_busy    <= 1'b0;
          r_done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_weight_row_loader.sv
// Self-checking bench for ex_weight_row_loader: a table of whole loads with
// hand-computed write cycles, indices and done timing, plus directed
// sequences for ignored restarts and asynchronous reset mid-fill/mid-write.
module tb_ex_weight_row_loader;

  localparam int DW = 14;
  localparam int BL = 16;
  localparam int LN = 256;
  localparam int IW = 10;

  logic                clk;
  logic                rst;
  logic                start;
  logic [IW-1:0]       base_index;
  logic [IW-1:0]       num_rows;
  logic                s_valid;
  logic [BL*DW-1:0]    s_data;
  logic                s_ready;
  logic [LN*DW-1:0]    mem_data;
  logic [IW-1:0]       mem_index;
  logic                mem_en;
  logic                mem_wr;
  logic                mem_rd;
  logic                busy;
  logic                done;
  logic                err;

  int n_checks = 0;
  int n_fail   = 0;

  ex_weight_row_loader #(
    .Data_Width (DW),
    .Lanes      (LN),
    .Beat_Lanes (BL),
    .Height     (938),
    .Index_Width(IW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_index(base_index),
    .num_rows  (num_rows),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .mem_data  (mem_data),
    .mem_index (mem_index),
    .mem_en    (mem_en),
    .mem_wr    (mem_wr),
    .mem_rd    (mem_rd),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [IW-1:0] base;
    logic [IW-1:0] num;
    bit            tog;
    bit            eerr;
    logic [DW-1:0] seed;
    int            period;
    int            done_cyc;
    int            last_idx;
    int            writes;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [BL*DW-1:0] beat_data(input logic [DW-1:0] seed, input int row, input int beat);
    logic [BL*DW-1:0] v;
    v = '0;
    for (int j = 0; j < BL; j++) v[j*DW +: DW] = DW'(int'(seed) + row*LN + beat*BL + j);
    return v;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_s_ready"}, 64'(s_ready), 64'd0);
    check({tag, "_mem_en"}, 64'(mem_en), 64'd0);
    check({tag, "_mem_wr"}, 64'(mem_wr), 64'd0);
    check({tag, "_mem_rd"}, 64'(mem_rd), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_mem_index"}, 64'(mem_index), 64'd0);
    check({tag, "_mem_data_zero"}, 64'(mem_data == '0), 64'd1);
  endtask

  // Runs one load and checks every write, done timing and ready behaviour.
  task automatic do_load(input logic [IW-1:0] b, input logic [IW-1:0] n, input bit tog,
                         input bit eerr, input logic [DW-1:0] seed, input int e_period,
                         input int e_done, input int e_last, input int e_writes,
                         input int restart_at);
    int k, wr, drow, dbeat, rdy_bad, junk;
    bit phase, seen_done;
    logic [DW-1:0] a_l, e_l;
    @(negedge clk);
    start = 1'b1; base_index = b; num_rows = n; s_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; base_index = ~b; num_rows = ~n;
    if (eerr) begin
      @(negedge clk);
      check("err_flag", 64'(err), 64'd1);
      check("err_busy", 64'(busy), 64'd0);
      junk = 0;
      repeat (20) begin
        @(negedge clk);
        if (mem_wr || busy || s_ready) junk++;
      end
      check("err_no_activity", 64'(junk), 64'd0);
      return;
    end
    k = 0; wr = 0; drow = 0; dbeat = 0; rdy_bad = 0; phase = 1'b0; seen_done = 1'b0;
    while (!seen_done && k < 2000) begin
      @(negedge clk); k++;
      if (k == 1) begin
        check("start_busy", 64'(busy), 64'd1);
        check("start_s_ready", 64'(s_ready), 64'd1);
        check("start_err_clear", 64'(err), 64'd0);
      end
      if (k == restart_at) begin
        start = 1'b1; base_index = 10'd40; num_rows = 10'd5;
      end else begin
        start = 1'b0;
      end
      if (mem_wr) begin
        check("wr_cycle", 64'(k), 64'((wr + 1) * e_period));
        check("wr_index", 64'(mem_index), 64'(int'(b) + wr));
        check("wr_en", 64'(mem_en), 64'd1);
        check("wr_s_ready", 64'(s_ready), 64'd0);
        a_l = mem_data[0 +: DW]; e_l = DW'(int'(seed) + wr*LN);
        for (int i = LN - 1; i >= 0; i--) begin
          if (mem_data[i*DW +: DW] !== DW'(int'(seed) + wr*LN + i)) begin
            a_l = mem_data[i*DW +: DW]; e_l = DW'(int'(seed) + wr*LN + i);
          end
        end
        check("wr_data_lane", 64'(a_l), 64'(e_l));
        wr++;
      end else if (!done) begin
        if (s_ready !== 1'b1 || mem_en !== 1'b0) rdy_bad++;
      end
      if (done) begin
        check("done_cycle", 64'(k), 64'(e_done));
        check("done_writes", 64'(wr), 64'(e_writes));
        check("done_busy", 64'(busy), 64'd1);
        seen_done = 1'b1;
      end
      if (tog) begin
        s_valid = phase;
        if (s_ready) phase = !phase;
      end else begin
        s_valid = 1'b1;
      end
      s_data = beat_data(seed, drow, dbeat);
      if (s_ready && s_valid) begin
        dbeat++;
        if (dbeat == LN / BL) begin dbeat = 0; drow++; end
      end
    end
    start = 1'b0;
    if (!seen_done) check("done_timeout", 64'd0, 64'd1);
    check("ready_outside_write", 64'(rdy_bad), 64'd0);
    check("last_index_held", 64'(mem_index), 64'(e_last));
    @(negedge clk);
    s_valid = 1'b0;
    check("post_done_low", 64'(done), 64'd0);
    check("post_busy_low", 64'(busy), 64'd0);
    check("post_mem_wr_low", 64'(mem_wr), 64'd0);
  endtask

  initial begin
    int cnt;
    bit hit;
    tbl[0] = '{10'd5,   10'd1, 1'b0, 1'b0, 14'd0,   17, 18,  5,   1};
    tbl[1] = '{10'd0,   10'd3, 1'b0, 1'b0, 14'd100, 17, 52,  2,   3};
    tbl[2] = '{10'd0,   10'd3, 1'b1, 1'b0, 14'd100, 33, 100, 2,   3};
    tbl[3] = '{10'd930, 10'd9, 1'b0, 1'b1, 14'd0,   0,  0,   0,   0};
    tbl[4] = '{10'd929, 10'd9, 1'b0, 1'b0, 14'd7,   17, 154, 937, 9};
    tbl[5] = '{10'd12,  10'd0, 1'b0, 1'b1, 14'd0,   0,  0,   0,   0};

    rst = 1'b0; start = 1'b0; base_index = '0; num_rows = '0; s_valid = 1'b0; s_data = '0;
    repeat (3) @(negedge clk);
    check_reset_values("por");
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("idle");

    for (int t = 0; t < 6; t++) begin
      do_load(tbl[t].base, tbl[t].num, tbl[t].tog, tbl[t].eerr, tbl[t].seed,
              tbl[t].period, tbl[t].done_cyc, tbl[t].last_idx, tbl[t].writes, 0);
    end

    // A start pulsed mid-load must not alter the row count or relaunch.
    do_load(10'd20, 10'd2, 1'b0, 1'b0, 14'd300, 17, 35, 21, 2, 5);
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (mem_wr || busy) cnt++;
    end
    check("restart_ignored", 64'(cnt), 64'd0);

    // Asynchronous reset after 7 beats of the first row.
    @(negedge clk);
    start = 1'b1; base_index = 10'd50; num_rows = 10'd2;
    @(posedge clk); #1;
    start = 1'b0;
    for (int bt = 0; bt < 7; bt++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data = beat_data(14'd500, 0, bt);
    end
    @(posedge clk); #2;
    rst = 1'b0; s_valid = 1'b0;
    #1;
    check_reset_values("rst_fill");
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (mem_wr || busy) cnt++;
    end
    check("rst_fill_quiet", 64'(cnt), 64'd0);
    rst = 1'b1;
    do_load(10'd50, 10'd2, 1'b0, 1'b0, 14'd900, 17, 35, 51, 2, 0);

    // Asynchronous reset during the write cycle drops mem_wr at once.
    @(negedge clk);
    start = 1'b1; base_index = 10'd3; num_rows = 10'd1;
    @(posedge clk); #1;
    start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      @(negedge clk);
      if (mem_wr) hit = 1'b1;
      else begin s_valid = 1'b1; s_data = beat_data(14'd11, 0, c); end
    end
    check("rst_wr_reached", 64'(hit), 64'd1);
    rst = 1'b0; s_valid = 1'b0;
    #1;
    check_reset_values("rst_write");
    @(negedge clk);
    rst = 1'b1;
    do_load(10'd3, 10'd1, 1'b0, 1'b0, 14'd12, 17, 18, 3, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 0, expected 1");
    $fatal(1);
  end

endmodule

// File: doc/ex_weight_row_loader.md
# ex_weight_row_loader

Write-side sequencer for the 256-lane expansion-weight row memory (`Memory_1x1_EX_bneck`). It accepts weights as a narrow valid/ready stream of `Beat_Lanes` lanes per beat and packs consecutive beats into one full `Lanes`-wide row. It then issues a single-cycle row write at `base_index + row`, repeating for `num_rows` rows. It sits between the off-chip weight DMA and the row memory, and drives that memory's `data_in`, `index`, `en`, `rd` and `wr` pins.

## Interface

Parameters:
- `Data_Width`, 14, bits per weight lane
- `Lanes`, 256, lanes per memory row
- `Beat_Lanes`, 16, lanes per input beat; must divide `Lanes`
- `Height`, 938, memory depth in rows
- `Index_Width`, 10, row index width

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request to begin a load; sampled only in IDLE
- `base_index`  in  Index_Width  first destination row; sampled with `start`
- `num_rows`  in  Index_Width  rows to load; sampled with `start`
- `s_valid`  in  1  input beat valid
- `s_data`  in  Beat_Lanes*Data_Width  input beat; lane j occupies bits [j*Data_Width +: Data_Width]
- `s_ready`  out  1  loader accepts a beat this cycle
- `mem_data`  out  Lanes*Data_Width  packed row to memory `data_in`
- `mem_index`  out  Index_Width  row address to memory `index`
- `mem_en`  out  1  memory enable
- `mem_wr`  out  1  memory write strobe
- `mem_rd`  out  1  memory read strobe; constant 0
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse after the final row write
- `err`  out  1  sticky parameter-error flag

## Operation

- BPR = `Lanes`/`Beat_Lanes` is the number of beats per row (16 at the defaults).
- State IDLE:
  - On `start`, if `num_rows`==0 or `base_index`+`num_rows` > `Height` (computed at Index_Width+1 bits): set `err`=1 and stay in IDLE.
  - Otherwise: clear `err`, latch the parameters, set row=0 and beat=0, and go to FILL.
- State FILL:
  - `s_ready`=1.
  - On a beat handshake (`s_valid`&&`s_ready`), write `s_data` lane j into buffer lane beat*`Beat_Lanes`+j, then increment beat.
  - When the handshake occurs with beat==BPR-1, set beat to 0 and go to WRITE.
- State WRITE (exactly one cycle):
  - `s_ready`=0, `mem_en`=1, `mem_wr`=1, `mem_index`=base+row, `mem_data`=buffer.
  - Then increment row. If row+1==num_rows go to DONE, else go to FILL.
- State DONE (one cycle): `done`=1, then go to IDLE.
- `start` outside IDLE is ignored.
- Lanes of the buffer not yet overwritten keep their old values. Every row is fully rewritten before its WRITE, so no clearing is needed.
- `mem_data` is driven directly from the buffer register, so it changes only on accepted beats.
- `mem_index` is registered. It holds its last value outside WRITE.
- `mem_en` and `mem_wr` are 0 outside WRITE.

## Timing

- Reset values:
  - State IDLE.
  - `s_ready`, `mem_en`, `mem_wr`, `mem_rd`, `busy`, `done`, `err` all 0.
  - `mem_index`=0 and the buffer (`mem_data`) all 0.
  - Row and beat counters 0.
- `start` sampled at edge N: `busy`=1 and `s_ready`=1 from cycle N+1.
- The last beat of a row is accepted at edge M: WRITE is active in cycle M+1 (`mem_wr` high for exactly one cycle), and `s_ready` returns to 1 in cycle M+2.
- Sustained throughput with `s_valid` held high: BPR+1 cycles per row (17 at the defaults).
- `done` is high in the cycle after the final WRITE. `busy` falls together with the return to IDLE.
- `s_valid` low stalls FILL indefinitely with no state change. The handshake is evaluated every cycle, and there is no timeout.
- `rst` asserted at any point, including mid-FILL or mid-WRITE, immediately forces the reset values. A partially loaded row is discarded and `mem_wr` drops asynchronously.
- Maximum legal load: `base_index`+`num_rows`==`Height`, so the last index written is `Height`-1.

## Test plan

- Reset, then `start` with `base_index`=5, `num_rows`=1, and 16 beats where lane j of beat k = k*16+j -> exactly one `mem_wr` pulse at `mem_index`=5; `mem_data` lane i = i for i = 0..255; then `done` pulses once.
- `start` with `base_index`=0, `num_rows`=3 and `s_valid` held high -> `mem_wr` at indices 0, 1, 2 in cycles 17, 34, 51 after `start`; `done` in cycle 52.
- Same load with `s_valid` toggling on alternate cycles -> identical writes and data; each row takes 33 cycles; `s_ready` is 0 only during WRITE cycles.
- `start` with `base_index`=930, `num_rows`=9 -> `err`=1, `busy` stays 0, no `mem_wr`. A following valid `start` with `base_index`=929, `num_rows`=9 -> `err` clears and the last write lands at index 937.
- `start` with `num_rows`=0 -> `err`=1. A second `start` pulsed during an active load -> ignored; the row count is unchanged.
- Assert `rst` after 7 beats of the first row -> all outputs return to their reset values and no `mem_wr` occurs. A fresh `start` then completes normally.
